// File: rtl/qlf_k6n10f_sh_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | qlf_k6n10f_sh_pkg : shared types and sizing helpers for the sh chain IP  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package qlf_k6n10f_sh_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_STALL = 2'd2,
        ST_FLUSH = 2'd3
    } sh_state_e;

    // Bits needed to hold any value in 0..max_val (at least one bit).
    function automatic int sh_cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int sh_word_count(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

    localparam int SH_DEF_NUM_WORDS = sh_word_count(64, 8);

endpackage
`default_nettype wire

// File: rtl/sh_chain_deser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sh_chain_deser : LSB-first bit assembler with zero-padded partial words  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sh_chain_deser
    import qlf_k6n10f_sh_pkg::*;
#(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              cap,
    input  logic              end_word,
    input  logic              so,
    output logic [WORD_W-1:0] word,
    output logic              full
);

    localparam int            BW       = sh_cnt_width(WORD_W - 1);
    localparam logic [BW-1:0] LAST_IDX = BW'(WORD_W - 1);

    logic [WORD_W-1:0] r_asm;
    logic [BW-1:0]     r_bit_cnt;
    logic [WORD_W-1:0] w_low_mask;
    logic [WORD_W-1:0] w_merged;

    // Bits at and above the current index are forced to zero, which pads a short last word.
    always_comb begin
        w_low_mask = (WORD_W'(1) << r_bit_cnt) - WORD_W'(1);
        w_merged   = (r_asm & w_low_mask) | (WORD_W'(so) << r_bit_cnt);
    end

    assign word = cap ? w_merged : r_asm;
    assign full = (r_bit_cnt == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_asm     <= '0;
            r_bit_cnt <= '0;
        end else if (cap) begin
            r_asm     <= w_merged;
            r_bit_cnt <= end_word ? '0 : r_bit_cnt + BW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/sh_chain_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sh_chain_reader : serial readback of an sh_dff chain onto a word stream  |
// | Option macro SH_CHAIN_RECIRC_EN: recirculate bits for non-destructive rd |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sh_chain_reader
    import qlf_k6n10f_sh_pkg::*;
#(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8
) (
    input  logic              C,
    input  logic              R,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              chain_so,
    output logic              chain_shift,
    output logic              chain_si,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              word_last
);

    localparam int            TW       = sh_cnt_width(CHAIN_LEN);
    localparam logic [TW-1:0] LAST_BIT = TW'(CHAIN_LEN - 1);
    localparam logic [TW-1:0] ALL_BITS = TW'(CHAIN_LEN);

    sh_state_e         r_state;
    sh_state_e         w_next;
    logic [TW-1:0]     r_total;
    logic [WORD_W-1:0] r_data;
    logic              r_valid;
    logic              r_last;
    logic              r_done;

    logic              w_hs;
    logic              w_room;
    logic              w_last_bit;
    logic              w_full;
    logic              w_word_end;
    logic              w_shifting;
    logic              w_load_shift;
    logic              w_load_stall;
    logic              w_clr;
    logic [WORD_W-1:0] w_word;

    assign w_hs         = r_valid & word_ready;
    assign w_room       = ~r_valid | word_ready;
    assign w_last_bit   = (r_total == LAST_BIT);
    assign w_word_end   = w_full | w_last_bit;
    assign w_shifting   = (r_state == ST_SHIFT);
    assign w_load_shift = w_shifting & w_word_end & w_room;
    assign w_load_stall = (r_state == ST_STALL) & w_hs;
    assign w_clr        = w_load_shift | w_load_stall | (r_state == ST_IDLE);

    sh_chain_deser #(
        .WORD_W (WORD_W)
    ) u_deser (
        .clk      (C),
        .rst      (R),
        .clr      (w_clr),
        .cap      (w_shifting),
        .end_word (w_word_end),
        .so       (chain_so),
        .word     (w_word),
        .full     (w_full)
    );

    always_ff @(posedge C) begin
        if (R) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next = ST_SHIFT;
            ST_SHIFT: begin
                if (w_word_end) begin
                    if (!w_room)         w_next = ST_STALL;
                    else if (w_last_bit) w_next = ST_FLUSH;
                end
            end
            ST_STALL: if (w_hs) w_next = (r_total == ALL_BITS) ? ST_FLUSH : ST_SHIFT;
            ST_FLUSH: if (w_hs) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge C) begin
        if (R) begin
            r_total <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= (r_state == ST_FLUSH) & w_hs;
            if (r_state == ST_IDLE && start) begin
                r_total <= '0;
            end else if (w_shifting) begin
                r_total <= r_total + TW'(1);
            end
            if (w_load_shift || w_load_stall) begin
                r_data  <= w_word;
                r_valid <= 1'b1;
                r_last  <= w_load_shift ? w_last_bit : (r_total == ALL_BITS);
            end else if (w_hs) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

    // Reset takes precedence over the cell enable so a reset cycle never moves the chain.
    always_comb begin
        chain_shift = w_shifting & ~R;
        chain_si    = 1'b0;
`ifdef SH_CHAIN_RECIRC_EN
        chain_si    = w_shifting & ~R & chain_so;
`else
        chain_si    = 1'b0;
`endif
        busy        = (r_state != ST_IDLE) | r_done;
        done        = r_done;
        word_data   = r_data;
        word_valid  = r_valid;
        word_last   = r_last;
    end

endmodule
`default_nettype wire

// File: tb/tb_sh_chain_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sh_chain_reader : directed scoreboard bench for sh_chain_reader       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_sh_chain_reader;

`ifdef SH_CHAIN_RECIRC_EN
    localparam bit RECIRC = 1'b1;
`else
    localparam bit RECIRC = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } exp_t;

    logic        C = 1'b0;
    logic        R = 1'b1;
    logic        start = 1'b0;
    logic        word_ready = 1'b1;
    logic        busy, done, chain_so, chain_shift, chain_si, word_valid, word_last;
    logic [7:0]  word_data;
    logic [15:0] chain;
    logic        load_en = 1'b0;
    logic [15:0] load_val = '0;

    logic        start_b = 1'b0;
    logic        busy_b, done_b, so_b, shift_b, si_b, valid_b, last_b;
    logic [7:0]  data_b;
    logic [11:0] chain_b;
    logic        load_en_b = 1'b0;
    logic [11:0] load_val_b = '0;

    exp_t sbq[$];
    exp_t qb[$];
    int   total = 0;
    int   bad = 0;
    int   ecnt = 0;
    int   e0 = 0;
    int   shift_cnt, busy_cnt, done_cyc, last_shift_cyc, done_b_cyc;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_d = '0;
    logic       prev_l = 1'b0;

    always #5 C = ~C;

    sh_chain_reader #(.CHAIN_LEN(16), .WORD_W(8)) dut (
        .C(C), .R(R), .start(start), .busy(busy), .done(done),
        .chain_so(chain_so), .chain_shift(chain_shift), .chain_si(chain_si),
        .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
        .word_last(word_last)
    );

    sh_chain_reader #(.CHAIN_LEN(12), .WORD_W(8)) dut_b (
        .C(C), .R(R), .start(start_b), .busy(busy_b), .done(done_b),
        .chain_so(so_b), .chain_shift(shift_b), .chain_si(si_b),
        .word_data(data_b), .word_valid(valid_b), .word_ready(1'b1),
        .word_last(last_b)
    );

    // Behavioural sh_dff chains: tail cell is bit 0, head is the top bit.
    assign chain_so = chain[0];
    assign so_b     = chain_b[0];
    always @(posedge C) begin
        if (load_en)          chain <= load_val;
        else if (chain_shift) chain <= {chain_si, chain[15:1]};
        if (load_en_b)        chain_b <= load_val_b;
        else if (shift_b)     chain_b <= {si_b, chain_b[11:1]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic l);
        exp_t e;
        e.d = d;
        e.l = l;
        sbq.push_back(e);
    endtask

    // Sample on the falling edge, then advance one rising edge.
    task automatic step();
        int   cyc;
        exp_t e;
        @(negedge C);
        cyc = ecnt - e0 + 1;
        if (chain_shift) begin
            shift_cnt++;
            last_shift_cyc = cyc;
        end
        if (busy) busy_cnt++;
        if (done && done_cyc < 0) done_cyc = cyc;
        if (done_b && done_b_cyc < 0) done_b_cyc = cyc;
        if (prev_stall) begin
            chk("hold_valid", 32'(word_valid), 32'd1);
            chk("hold_data", 32'(word_data), 32'(prev_d));
            chk("hold_last", 32'(word_last), 32'(prev_l));
        end
        prev_stall = word_valid && !word_ready;
        prev_d     = word_data;
        prev_l     = word_last;
        if (word_valid && word_ready) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected_word", 32'(word_valid), 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("sb_data", 32'(word_data), 32'(e.d));
                chk("sb_last", 32'(word_last), 32'(e.l));
            end
        end
        if (valid_b) begin
            e.d = data_b;
            e.l = last_b;
            qb.push_back(e);
        end
        @(posedge C);
        ecnt++;
        #1;
    endtask

    task automatic load(input logic [15:0] v);
        load_val = v;
        load_en  = 1'b1;
        step();
        load_en  = 1'b0;
    endtask

    task automatic begin_read();
        shift_cnt      = 0;
        busy_cnt       = 0;
        done_cyc       = -1;
        last_shift_cyc = -1;
        prev_stall     = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        e0 = ecnt;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 80 && done_cyc < 0; i++) step();
        chk(tag, 32'(done_cyc >= 0), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_done"},  32'(done), 32'd0);
        chk({tag, "_shift"}, 32'(chain_shift), 32'd0);
        chk({tag, "_si"},    32'(chain_si), 32'd0);
        chk({tag, "_valid"}, 32'(word_valid), 32'd0);
        chk({tag, "_last"},  32'(word_last), 32'd0);
        chk({tag, "_data"},  32'(word_data), 32'd0);
    endtask

    initial begin
        done_b_cyc = -1;
        step();
        step();
        check_reset_outputs("reset");
        R = 1'b0;

        // Unstalled readback of 0xA55A.
        word_ready = 1'b1;
        load(16'hA55A);
        push_exp(8'h5A, 1'b0);
        push_exp(8'hA5, 1'b1);
        begin_read();
        for (int i = 0; i < 20 && !word_valid; i++) step();
        chk("first_valid_cycle", 32'(ecnt - e0 + 1), 32'd9);
        wait_done("t1_done_seen");
        chk("t1_done_cycle", 32'(done_cyc), 32'd18);
        chk("t1_shift_count", 32'(shift_cnt), 32'd16);
        chk("t1_last_shift_cycle", 32'(last_shift_cyc), 32'd16);
        chk("t1_busy_cycles", 32'(busy_cnt), 32'd18);
        step();
        chk("t1_busy_after", 32'(busy), 32'd0);
        chk("t1_sb_empty", 32'(sbq.size()), 32'd0);
        chk("t1_chain_after", 32'(chain), RECIRC ? 32'hA55A : 32'h0);

        // Backpressure: ready low from start, held low 20 cycles past first valid.
        load(16'hA55A);
        push_exp(8'h5A, 1'b0);
        push_exp(8'hA5, 1'b1);
        word_ready = 1'b0;
        begin_read();
        for (int i = 0; i < 40 && !word_valid; i++) step();
        chk("t2_first_valid_cycle", 32'(ecnt - e0 + 1), 32'd9);
        repeat (20) step();
        chk("t2_shift_count_stalled", 32'(shift_cnt), 32'd16);
        chk("t2_last_shift_cycle", 32'(last_shift_cyc), 32'd16);
        chk("t2_shift_low", 32'(chain_shift), 32'd0);
        chk("t2_valid_held", 32'(word_valid), 32'd1);
        word_ready = 1'b1;
        wait_done("t2_done_seen");
        chk("t2_shift_count", 32'(shift_cnt), 32'd16);
        chk("t2_sb_empty", 32'(sbq.size()), 32'd0);

        // Reset five cycles into the shift, then read the remainder.
        load(16'hA55A);
        begin_read();
        repeat (5) step();
        chk("t3_shift_before_reset", 32'(shift_cnt), 32'd5);
        R = 1'b1;
        step();
        check_reset_outputs("t3_midreset");
        R = 1'b0;
        chk("t3_chain_after_reset", 32'(chain), RECIRC ? 32'hD52A : 32'h052A);
        push_exp(8'h2A, 1'b0);
        push_exp(RECIRC ? 8'hD5 : 8'h05, 1'b1);
        begin_read();
        wait_done("t3_done_seen");
        chk("t3_done_cycle", 32'(done_cyc), 32'd18);
        chk("t3_sb_empty", 32'(sbq.size()), 32'd0);

        // Reset and start together: reset wins.
        R = 1'b1;
        start = 1'b1;
        step();
        R = 1'b0;
        start = 1'b0;
        step();
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_shift", 32'(chain_shift), 32'd0);

        // Two consecutive readbacks of 0x3C3C.
        load(16'h3C3C);
        push_exp(8'h3C, 1'b0);
        push_exp(8'h3C, 1'b1);
        begin_read();
        wait_done("t5a_done_seen");
        push_exp(RECIRC ? 8'h3C : 8'h00, 1'b0);
        push_exp(RECIRC ? 8'h3C : 8'h00, 1'b1);
        step();
        begin_read();
        wait_done("t5b_done_seen");
        chk("t5_sb_empty", 32'(sbq.size()), 32'd0);

        // Twelve-cell chain of ones: second word zero-padded.
        load_val_b = 12'hFFF;
        load_en_b  = 1'b1;
        step();
        load_en_b  = 1'b0;
        qb.delete();
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        e0 = ecnt;
        done_b_cyc = -1;
        for (int i = 0; i < 40 && done_b_cyc < 0; i++) step();
        chk("t6_done_cycle", 32'(done_b_cyc), 32'd14);
        chk("t6_word_count", 32'(qb.size()), 32'd2);
        if (qb.size() == 2) begin
            chk("t6_w0_data", 32'(qb[0].d), 32'hFF);
            chk("t6_w0_last", 32'(qb[0].l), 32'd0);
            chk("t6_w1_data", 32'(qb[1].d), 32'h0F);
            chk("t6_w1_last", 32'(qb[1].l), 32'd1);
        end
        step();
        chk("t6_busy_after", 32'(busy_b), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sh_chain_reader.md
# sh_chain_reader

Serial readback controller for a chain of `sh_dff` shift cells on the QLF K6N10F fabric. It is the unloading end of the shift chain. It clocks the chain out one bit per cycle from its tail, packs the bits LSB-first into words, and delivers them on a valid/ready stream to the debug/config host. Backpressure stalls the chain. A preprocessor option makes readback non-destructive by recirculating each bit into the chain head.

## Interface
Parameters:
- `CHAIN_LEN`, 64: number of `sh_dff` cells in the chain (≥1).
- `WORD_W`, 8: output word width (≥1).

Ports:
- `C`, in, 1: clock. All logic is on the rising edge.
- `R`, in, 1: reset. One clock; reset is synchronous and active-high.
- `start`, in, 1: single-cycle request to begin readback.
- `busy`, out, 1: high from the cycle after `start` is accepted until `done`.
- `done`, out, 1: one-cycle pulse after the last word handshake.
- `chain_so`, in, 1: serial output of the chain tail cell.
- `chain_shift`, out, 1: chain clock-enable. The chain advances one cell on each rising edge of `C` with this high.
- `chain_si`, out, 1: serial input driven into the chain head.
- `word_data`, out, WORD_W: packed word. Bit 0 is the first bit shifted out.
- `word_valid`, out, 1: `word_data` is valid.
- `word_ready`, in, 1: consumer accepts the word.
- `word_last`, out, 1: qualifies the final word of the chain.

## Operation
- States:
  - IDLE: waits for `start`.
  - SHIFT: collects bits.
  - STALL: assembled word complete but the output register is full.
  - FLUSH: all bits taken; waits for the last handshake.
- IDLE → SHIFT: on `start` with `R` low. `start` is ignored outside IDLE.
- SHIFT behaviour:
  - `chain_shift` is high.
  - Each cycle, `chain_so` is captured into the assembly register at bit index `bit_cnt`.
  - `bit_cnt` wraps to 0 at WORD_W, and `total_cnt` increments.
- Word complete, or `total_cnt` reaching CHAIN_LEN:
  - If the output register is empty, or being drained this cycle (`word_valid && word_ready`), the word transfers into the output register and shifting continues without a gap.
  - Otherwise the state goes to STALL. `chain_shift` is low and no bits are lost.
- STALL → SHIFT (or FLUSH, if this was the last word): the transfer happens on the handshake cycle.
- Last word:
  - Word count is ceil(CHAIN_LEN/WORD_W).
  - If CHAIN_LEN is not a multiple of WORD_W, the unused upper bits of the last word are zero.
  - `word_last` is high with that word only.
- FLUSH → IDLE: on the handshake of the last word. `done` pulses the following cycle.
- Output stream:
  - `word_data` and `word_last` hold stable while `word_valid && !word_ready`.
  - `word_valid` never drops without a handshake.
- `chain_si`: see Configuration. It is meaningful only while `chain_shift` is high and is 0 otherwise.

## Timing
- Reset values: `busy` 0, `done` 0, `chain_shift` 0, `chain_si` 0, `word_valid` 0, `word_last` 0, `word_data` 0. State is IDLE and all counters are 0.
- Reset mid-operation: the controller returns to IDLE next cycle and any pending word is discarded. The chain is left partially shifted; the host must reload it.
- Latency:
  - `start` sampled at edge 0 → `chain_shift` high cycles 1..CHAIN_LEN (with no stalls).
  - First `word_valid` is at cycle WORD_W+1.
- Throughput: 1 bit/cycle with `word_ready` tied high. Total busy time is CHAIN_LEN+2 cycles.
- `R` and `start` high in the same cycle: reset wins and `start` is dropped.
- CHAIN_LEN == 1: a single word with bit 0 = cell value and `word_last` = 1.

## Configuration
- `SH_CHAIN_RECIRC_EN` defined: `chain_si` = `chain_so` while shifting. After a complete readback, the chain holds its original contents (non-destructive readback).
- `SH_CHAIN_RECIRC_EN` not defined: `chain_si` = 0. After a complete readback, every chain cell reads 0, matching the cells' power-up value.

## Structure
- Shared package `qlf_k6n10f_sh_pkg`:
  - state enum (IDLE/SHIFT/STALL/FLUSH);
  - function computing counter widths from CHAIN_LEN and WORD_W;
  - constant for the word count ceil(CHAIN_LEN/WORD_W).
- One sub-module, `sh_chain_deser`, owns:
  - the assembly register;
  - `bit_cnt`;
  - the zero-padding of the partial word.
- The top owns the FSM, `total_cnt`, the output register and the handshake.

## Test plan
- CHAIN_LEN=16, WORD_W=8, chain loaded 0xA55A (LSB out first), `word_ready`=1:
  - words 0x5A then 0xA5;
  - `word_last` on the second word;
  - `done` at cycle 18 after `start`.
- CHAIN_LEN=12, WORD_W=8, chain all ones: words 0xFF then 0x0F with `word_last`=1.
- Backpressure, with `word_ready` low for 20 cycles after the first `word_valid`:
  - `chain_shift` drops after 8 further bits;
  - no bit is lost;
  - data matches the unstalled run.
- `R` asserted 5 cycles into SHIFT:
  - next cycle, all outputs are at reset values;
  - a new `start` reads back the remaining shifted contents correctly.
- `SH_CHAIN_RECIRC_EN` defined, pattern 0x3C3C:
  - two consecutive readbacks both return 0x3C, 0x3C.
- `SH_CHAIN_RECIRC_EN` undefined, pattern 0x3C3C:
  - the second readback returns 0x00, 0x00.
